btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Input-side companion to the LED drivers: conditions raw push-button inputs from the board into clean, single-clock-domain signals for the rest of the design.
- Per button: 2-flop synchronizer, debounce state machine, debounced level, and one-cycle press/release pulses.
- Also keeps a wrapping 8-bit total-press counter that can be shown on LEDs.
- Runs entirely in the sys_clk_125 domain.

Parameters:
- N_BTN, 4, number of button channels (1..8).
- DEBOUNCE_CYCLES, 1_250_000, consecutive stable cycles required before a level change is accepted (10 ms at 125 MHz); legal range >= 2.

Ports:
- sys_clk_125  input  1  system clock, 125 MHz; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  N_BTN  raw, asynchronous, bouncing button levels (1 = pressed).
- btn_state  output  N_BTN  debounced level per channel.
- btn_press  output  N_BTN  one-cycle pulse when a channel's debounced level goes 0->1.
- btn_release  output  N_BTN  one-cycle pulse when a channel's debounced level goes 1->0.
- press_count  output  8  total accepted presses across all channels, wraps modulo 256.

Behaviour:
- Reset (asynchronous assert, released synchronously by the board):
  - sync flops, FSMs (RELEASED), debounce counters, btn_state, btn_press, btn_release and press_count all go to 0.
  - Reset asserted mid-debounce discards the pending change; no pulse is emitted.
- Synchronizer: btn[i] -> s1[i] -> s2[i], both reset to 0. Only s2 feeds the FSM.
- Per-channel FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; counter width $clog2(DEBOUNCE_CYCLES).
  - RELEASED: s2=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - s2=0 -> RELEASED; bounce rejected, no pulse.
    - else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, btn_state<=1, btn_press pulse.
    - else cnt++.
  - PRESSED: s2=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT:
    - s2=1 -> PRESSED, no pulse.
    - else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED, btn_state<=0, btn_release pulse.
    - else cnt++.
- Latency: for a clean step on btn, number the first rising edge that samples the new level as edge 1. btn_state changes and the pulse is high after edge DEBOUNCE_CYCLES+3.
- Pulse rules:
  - btn_press and btn_release are registered and high for exactly one cycle.
  - btn_press coincides with the cycle btn_state first reads 1; btn_release with the cycle it first reads 0.
  - The two are never high together on one channel.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) never changes btn_state. Each reversal restarts the count from 0.
- Channels are fully independent; no priority between them.
- press_count:
  - On the cycle after btn_press pulses, press_count <= press_count + popcount(btn_press). Simultaneous presses on k channels add k in one step.
  - Arithmetic is 8-bit modulo: 254 + 3 = 1.
  - Releases do not affect the count.
- Holding a button indefinitely produces exactly one press pulse; there is no auto-repeat.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=4):
- Reset, then btn=0000 for 20 cycles -> btn_state=0000, no pulses, press_count=0. Assert rst mid-PRESS_WAIT on btn[0] -> all outputs 0 immediately, and no press pulse after rst drops unless the full debounce completes again.
- btn[0] clean step 0->1 -> btn_state[0]=1 and btn_press[0]=1 after edge 7 only, press_count=1 one cycle later. Then 1->0 -> btn_release[0] single pulse after edge 7, press_count stays 1.
- btn[1] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during the bounce. btn_state[1]=1 exactly 7 edges after the final rising sample.
- btn[2] held high 100 cycles with 3-cycle low glitches every 20 cycles -> exactly one btn_press[2], zero btn_release[2], btn_state[2] stays 1.
- btn=1111 stepped in the same cycle with press_count preloaded to 254 via 254 prior presses -> all four press pulses in one cycle, press_count goes 254->2 in a single step.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop sync, debounce FSM,
// debounced level, press/release pulses and a wrapping press counter.
//
// Ports:
//   sys_clk_125 : system clock, all logic on rising edge
//   rst         : asynchronous active-high reset
//   btn         : raw bouncing button levels (1 = pressed)
//   btn_state   : debounced level per channel
//   btn_press   : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0
//   press_count : total accepted presses, modulo 256
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic             sys_clk_125,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [7:0]       press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;

  state_e        state_q [N_BTN];
  state_e        state_d [N_BTN];
  logic [CW-1:0] cnt_q   [N_BTN];
  logic [CW-1:0] cnt_d   [N_BTN];

  logic [N_BTN-1:0] lvl_q;
  logic [N_BTN-1:0] lvl_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] rel_q;
  logic [N_BTN-1:0] rel_d;

  logic [7:0] total_q;
  logic [7:0] total_d;
  logic [7:0] npress;

  // Synchronizer: only s2 is ever used by the debounce logic.
  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end

  // Per-channel debounce FSM. The count restarts on every reversal,
  // so only an uninterrupted run of the new level is accepted.
  always_comb begin
    lvl_d   = lvl_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        RELEASED: begin
          if (s2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[i]) begin
            state_d[i] = RELEASED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            lvl_d[i]   = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2_q[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = RELEASED;
            lvl_d[i]   = 1'b0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      lvl_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Counter adds the registered press pulses, so it trails
  // btn_press by one cycle; simultaneous presses add together.
  always_comb begin
    npress = '0;
    for (int i = 0; i < N_BTN; i++) begin
      npress = npress + 8'(press_q[i]);
    end
    total_d = total_q + npress;
  end

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign btn_state   = lvl_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign press_count = total_q;

endmodule
